// File: rtl/aes_defs_pkg.sv
// Shared AES-128 definitions: round count, controller encodings, state geometry,
// the S-box table and GF(2^8) helpers used by the round function.
package aes_defs_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int NUM_COLS       = 4;
  localparam int BYTES_PER_COL  = 4;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'b00,
    CTRL_ROUNDS = 2'b10
  } ctrl_state_e;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_round_fn.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (bypassed on the last round) and AddRoundKey. Byte i sits at [127-8i -: 8].
module aes_round_fn
  import aes_defs_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_state;
  logic [7:0]   shift_b [16];
  logic [7:0]   mix_b   [16];

  for (genvar c = 0; c < NUM_COLS; c++) begin : gen_sub
    byteSub u_byte_sub (
      .in_word  (state_in[127-32*c -: 32]),
      .out_word (sub_state[127-32*c -: 32])
    );
  end

  // Row r of column c takes the byte from column (c+r) mod 4 after substitution.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      shift_b[i] = 8'h00;
      mix_b[i]   = 8'h00;
    end
    state_out = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < BYTES_PER_COL; r++) begin
        shift_b[BYTES_PER_COL*c+r] =
          sub_state[127-8*(BYTES_PER_COL*((c+r)%NUM_COLS)+r) -: 8];
      end
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      mix_b[4*c+0] = xtime(shift_b[4*c+0]) ^ gmul3(shift_b[4*c+1]) ^ shift_b[4*c+2] ^ shift_b[4*c+3];
      mix_b[4*c+1] = shift_b[4*c+0] ^ xtime(shift_b[4*c+1]) ^ gmul3(shift_b[4*c+2]) ^ shift_b[4*c+3];
      mix_b[4*c+2] = shift_b[4*c+0] ^ shift_b[4*c+1] ^ xtime(shift_b[4*c+2]) ^ gmul3(shift_b[4*c+3]);
      mix_b[4*c+3] = gmul3(shift_b[4*c+0]) ^ shift_b[4*c+1] ^ shift_b[4*c+2] ^ xtime(shift_b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (last_round ? shift_b[i] : mix_b[i]) ^ rkey[127-8*i -: 8];
    end
  end

endmodule

// File: rtl/byteSub.sv
// Four parallel AES S-box substitutions over one 32-bit state column.
module byteSub
  import aes_defs_pkg::*;
(
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  assign out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                     sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128 encipher core: one round per clock, round keys fetched
// combinationally from the upstream key-expansion stage via round_idx.
module aes_encipher_core
  import aes_defs_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         key_ready,
  input  logic [127:0] key,
  input  logic [127:0] block_in,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);

  localparam logic [3:0] LastCnt = 4'(NUM_ROUNDS);

  ctrl_state_e  ctrl_q, ctrl_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] result_q, result_d;
  logic         valid_q, valid_d;
  logic [127:0] round_out;
  logic         last_round;

  assign last_round = (cnt_q == LastCnt);

  aes_round_fn u_round_fn (
    .state_in   (state_q),
    .rkey       (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= CTRL_IDLE;
      cnt_q    <= '0;
      state_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Round 0 (AddRoundKey with the raw key) is folded into the acceptance edge.
  always_comb begin
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (ctrl_q)
      CTRL_IDLE: begin
        if (start && key_ready) begin
          state_d = block_in ^ key;
          cnt_d   = 4'd1;
          ctrl_d  = CTRL_ROUNDS;
        end
      end
      CTRL_ROUNDS: begin
        state_d = round_out;
        if (last_round) begin
          result_d = round_out;
          valid_d  = 1'b1;
          cnt_d    = '0;
          ctrl_d   = CTRL_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        ctrl_d = CTRL_IDLE;
        cnt_d  = '0;
      end
    endcase
  end

  assign ready        = (ctrl_q == CTRL_IDLE);
  assign round_idx    = (ctrl_q == CTRL_ROUNDS) ? cnt_q : 4'd0;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_aes_encipher_core.sv
// Directed bench for aes_encipher_core using FIPS-197 vectors, with a local
// key-expansion model answering round_idx requests.
module tb_aes_encipher_core;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] E0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [0:255][7:0] SBOX_TB = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         key_ready;
  logic [127:0] key;
  logic [127:0] block_in;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         ready;
  logic [127:0] result;
  logic         result_valid;

  int errors = 0;
  int checks = 0;

  aes_encipher_core dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .key_ready    (key_ready),
    .key          (key),
    .block_in     (block_in),
    .round_idx    (round_idx),
    .round_key    (round_key),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES-128 key schedule: returns the round key for round r (0..10).
  function automatic logic [127:0] roundKeyOf(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    for (int i = 1; i <= 10; i++) begin
      if (i <= int'(r)) begin
        t  = {w3[23:0], w3[31:24]};
        t  = {SBOX_TB[t[31:24]], SBOX_TB[t[23:16]], SBOX_TB[t[15:8]], SBOX_TB[t[7:0]]};
        t  = t ^ {RCON[i-1], 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
      end
    end
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    round_key = '0;
    if (round_idx <= 4'd10) round_key = roundKeyOf(key, round_idx);
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launches one block from IDLE and follows it to the result_valid pulse.
  task automatic applyStimulus(input string tag, input logic [127:0] pt,
                               input logic [127:0] ct, input logic [127:0] e0);
    block_in = pt;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    block_in = ~pt;
    checkOutput({tag, "_busy"}, 128'(ready), 128'(1'b0));
    checkOutput({tag, "_idx1"}, 128'(round_idx), 128'(4'd1));
    checkOutput({tag, "_state_e0"}, dut.state_q, e0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      block_in = {$urandom, $urandom, $urandom, $urandom};
      checkOutput({tag, "_idx"}, 128'(round_idx), 128'(k + 1));
      checkOutput({tag, "_novalid"}, 128'(result_valid), 128'(1'b0));
    end
    @(negedge clk);
    checkOutput({tag, "_valid"}, 128'(result_valid), 128'(1'b1));
    checkOutput({tag, "_result"}, result, ct);
    checkOutput({tag, "_idx0"}, 128'(round_idx), 128'(4'd0));
    checkOutput({tag, "_ready"}, 128'(ready), 128'(1'b1));
    @(negedge clk);
    checkOutput({tag, "_valid_clr"}, 128'(result_valid), 128'(1'b0));
    checkOutput({tag, "_result_hold"}, result, ct);
  endtask

  initial begin
    int cyc;
    int pulses;
    int firstAt;
    bit seen;
    bit sawValid;

    reset_n   = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    key       = KEY_B;
    block_in  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 128'(ready), 128'(1'b1));
    checkOutput("rst_valid", 128'(result_valid), 128'(1'b0));
    checkOutput("rst_idx", 128'(round_idx), 128'(4'd0));
    checkOutput("rst_result", result, 128'h0);
    reset_n = 1'b1;

    // start without key_ready must be ignored
    start    = 1'b1;
    block_in = PT_B;
    repeat (5) begin
      @(negedge clk);
      checkOutput("gate_ready", 128'(ready), 128'(1'b1));
      checkOutput("gate_idx", 128'(round_idx), 128'(4'd0));
      checkOutput("gate_valid", 128'(result_valid), 128'(1'b0));
    end
    key_ready = 1'b1;
    applyStimulus("appB", PT_B, CT_B, E0_B);

    key = KEY_C;
    applyStimulus("appC1", PT_C, CT_C, PT_C ^ KEY_C);

    // back-to-back with start held high; key/block switch only in the valid cycle
    key      = KEY_B;
    block_in = PT_B;
    start    = 1'b1;
    cyc      = 0;
    pulses   = 0;
    firstAt  = 0;
    for (int n = 0; n < 40 && pulses < 2; n++) begin
      @(negedge clk);
      cyc++;
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin
          firstAt = cyc;
          checkOutput("b2b_first", result, CT_B);
          checkOutput("b2b_first_ready", 128'(ready), 128'(1'b1));
          key      = KEY_C;
          block_in = PT_C;
        end else begin
          checkOutput("b2b_second", result, CT_C);
          checkOutput("b2b_spacing", 128'(cyc - firstAt), 128'(11));
          start = 1'b0;
        end
      end else if (!ready) begin
        block_in = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    start = 1'b0;
    checkOutput("b2b_pulses", 128'(pulses), 128'(2));
    @(negedge clk);

    // asynchronous reset while round 5 is in flight
    key      = KEY_C;
    block_in = PT_C;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (round_idx == 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("mid_reached_idx5", 128'(seen), 128'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 128'(ready), 128'(1'b1));
    checkOutput("mid_rst_idx", 128'(round_idx), 128'(4'd0));
    checkOutput("mid_rst_valid", 128'(result_valid), 128'(1'b0));
    checkOutput("mid_rst_result", result, 128'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    sawValid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (result_valid) sawValid = 1'b1;
    end
    checkOutput("mid_no_valid", 128'(sawValid), 128'(1'b0));
    applyStimulus("appC1_after_rst", PT_C, CT_C, PT_C ^ KEY_C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_encipher_core.md
Name: aes_encipher_core

Overview:
- Iterative AES-128 encryption datapath. Computes one round per clock.
- Sits directly downstream of the key-expansion stage. Drives a 4-bit round index to it and consumes the 128-bit round key it returns combinationally.
- Accepts one plaintext block per start handshake. Delivers the ciphertext with a one-cycle valid pulse.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; fixed for AES-128, with the final round omitting MixColumns.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request to encrypt block_in; accepted only when ready=1 and key_ready=1.
- key_ready  input  1  key expansion complete; round keys 1..10 are valid.
- key  input  128  cipher key, used directly as round key 0.
- block_in  input  128  plaintext. Byte 0 = bits [127:120]; state is column-major per FIPS-197.
- round_idx  output  4  round whose key is requested from the key-expansion stage.
- round_key  input  128  key for round_idx, valid combinationally in the same cycle.
- ready  output  1  core idle and able to accept start.
- result  output  128  ciphertext; holds its value until the next accepted start completes.
- result_valid  output  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (asynchronous, any time, including mid-encryption):
  - fsm=IDLE, round counter=0, state register=0, result=0.
  - result_valid=0, ready=1, round_idx=0.
  - An in-flight block is discarded and no result_valid is produced for it.
- States: IDLE, ROUNDS.
- IDLE:
  - round_idx=0, ready=1.
  - At edge E0, start=1 and key_ready=1: state <= block_in ^ key; counter <= 1; go to ROUNDS.
  - start with key_ready=0 is ignored: no state change, no error flag.
- ROUNDS:
  - ready=0 and round_idx=counter (1..10).
  - Each edge: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round_key).
  - When counter=NUM_ROUNDS, MixColumns is bypassed.
  - counter increments by 1 each edge while counter<NUM_ROUNDS.
  - At the edge where counter=NUM_ROUNDS (E10):
    - result <= final state; result_valid <= 1.
    - counter <= 0; go to IDLE.
- result_valid is high in exactly the cycle after E10 and clears at the next edge.
- Latency: start sampled at E0 → result_valid high after E10, i.e. 10 cycles later. Throughput is one block per 11 cycles.
- Back-to-back operation:
  - start may be held high continuously.
  - A new block is accepted at the edge immediately following the result_valid assertion edge (ready=1 again in that cycle).
  - result_valid and the new acceptance coincide in the same cycle without conflict.
- start, block_in and key changes while in ROUNDS are ignored. block_in and key are sampled only at the acceptance edge.
- round_key is sampled only in ROUNDS. round_idx never presents values outside 0..10.
- GF(2^8) arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - Each MixColumns output byte = 2·a0 ^ 3·a1 ^ a2 ^ a3, rotated per row.
- S-box: 16 parallel byte substitutions using the existing 32-bit byteSub block (4 instances).

Decomposition:
- Shared package / include (aes_defs):
  - AES_NUM_ROUNDS=10.
  - FSM encodings CTRL_IDLE=2'b00, CTRL_ROUNDS=2'b10.
  - Byte/column index helper constants.
- Sub-module aes_round_fn (purely combinational):
  - Inputs: state_in[127:0], rkey[127:0], last_round.
  - Output: state_out[127:0].
  - Contains 4× byteSub, ShiftRows wiring, MixColumns with bypass, AddRoundKey.
- The core holds only the FSM, counter, state register and output registers.

Test Plan:
- FIPS-197 App. B (bench instantiates the key-expansion stage, drives it to key_ready):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required response: result 3925841d02dc09fbdc118597196a0b32. Internal state after E0 = 193de3bea0f4e22b9ac68d2ae9f84808.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required response: result 69c4e0d86a7b0430d8cdb78070b4c55a. result_valid high exactly 10 cycles after the start edge, for exactly 1 cycle.
- Handshake gating:
  - start held high with key_ready=0 for 5 cycles → fsm stays IDLE, round_idx=0, no result_valid.
  - Raise key_ready → accepted on the next edge.
- Back-to-back:
  - start held high across two blocks (App. B then App. C.1 plaintext, same key per run) → two result_valid pulses 11 cycles apart.
  - Changes to block_in during ROUNDS do not affect the result.
- Round index sequence: monitor round_idx across one encryption → 0,1,2,…,10,0; never exceeds 10.
- Reset mid-operation:
  - Assert reset_n=0 asynchronously while round_idx=5 → all outputs reset immediately, ready=1, no result_valid.
  - A fresh App. C.1 run afterwards produces the correct ciphertext.
